// File: rtl/csr_timer.sv
// csr_timer: LoongArch timer CSRs (TID 0x40, TCFG 0x41, TVAL 0x42, TICLR 0x44)
// plus the 64-bit stable counter read by rdcntvl.w / rdcntvh.w.
// Optional feature macro: CSR_STABLE_COUNTER_EN. When it is defined the 64-bit
// stable counter is built; otherwise cnt_vl/cnt_vh are tied to zero.
// CSR bus: a write is a single-cycle strobe (csr_we with csr_num/csr_wmask/
// csr_wvalue) consumed on the edge it is presented; there is no back-pressure.
// Reads are combinational and qualified by csr_re.
module csr_timer #(
    parameter int CSR_NUM_WIDTH = 14
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     csr_re,
    input  logic [CSR_NUM_WIDTH-1:0] csr_num,
    input  logic                     csr_we,
    input  logic [31:0]              csr_wmask,
    input  logic [31:0]              csr_wvalue,
    output logic [31:0]              timer_rvalue,
    output logic                     timer_int,
    output logic [31:0]              cnt_vl,
    output logic [31:0]              cnt_vh,
    output logic [31:0]              tid
);

    localparam logic [CSR_NUM_WIDTH-1:0] CSR_TID   = CSR_NUM_WIDTH'(8'h40);
    localparam logic [CSR_NUM_WIDTH-1:0] CSR_TCFG  = CSR_NUM_WIDTH'(8'h41);
    localparam logic [CSR_NUM_WIDTH-1:0] CSR_TVAL  = CSR_NUM_WIDTH'(8'h42);
    localparam logic [CSR_NUM_WIDTH-1:0] CSR_TICLR = CSR_NUM_WIDTH'(8'h44);

    logic [31:0] tcfg;
    logic [31:0] timer_cnt;
    logic [31:0] tcfg_next;
    logic [31:0] cnt_next;
    logic [31:0] reload_val;
    logic        tid_we;
    logic        tcfg_we;
    logic        ticlr_clr;
    logic        expire;

    assign tid_we    = csr_we && (csr_num == CSR_TID);
    assign tcfg_we   = csr_we && (csr_num == CSR_TCFG);
    assign ticlr_clr = csr_we && (csr_num == CSR_TICLR) && csr_wmask[0] && csr_wvalue[0];

    // Expiry is judged on the pre-edge enable and count, so a same-edge
    // TCFG rewrite cannot suppress an interrupt that was already due.
    assign expire = tcfg[0] && (timer_cnt == 32'd0);

    // Merge a TCFG write into the current config; the merged value steers the
    // counter on the same edge.
    always_comb begin
        tcfg_next = tcfg;
        if (tcfg_we) begin
            tcfg_next = (csr_wmask & csr_wvalue) | (~csr_wmask & tcfg);
        end
        reload_val = {tcfg_next[31:2], 2'b00};
    end

    // Next timer count: load on enabling write, otherwise count down, with a
    // periodic reload at zero and a one-shot freeze at all-ones.
    always_comb begin
        cnt_next = timer_cnt;
        if (tcfg_we && tcfg_next[0]) begin
            cnt_next = reload_val;
        end else if (tcfg_next[0] && (timer_cnt != 32'hFFFF_FFFF)) begin
            if ((timer_cnt == 32'd0) && tcfg_next[1]) begin
                cnt_next = reload_val;
            end else begin
                cnt_next = timer_cnt - 32'd1;
            end
        end
    end

    // TID, TCFG and timer count registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            tid       <= 32'd0;
            tcfg      <= 32'd0;
            timer_cnt <= 32'hFFFF_FFFF;
        end else begin
            if (tid_we) begin
                tid <= (csr_wmask & csr_wvalue) | (~csr_wmask & tid);
            end
            tcfg      <= tcfg_next;
            timer_cnt <= cnt_next;
        end
    end

    // Sticky interrupt flag; a new expiry beats a same-edge TICLR clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            timer_int <= 1'b0;
        end else if (expire) begin
            timer_int <= 1'b1;
        end else if (ticlr_clr) begin
            timer_int <= 1'b0;
        end
    end

`ifdef CSR_STABLE_COUNTER_EN
    logic [63:0] stable_cnt;

    // Free-running 64-bit stable counter, wraps naturally.
    always_ff @(posedge clk) begin
        if (reset) begin
            stable_cnt <= 64'd0;
        end else begin
            stable_cnt <= stable_cnt + 64'd1;
        end
    end

    assign cnt_vl = stable_cnt[31:0];
    assign cnt_vh = stable_cnt[63:32];
`else
    assign cnt_vl = 32'd0;
    assign cnt_vh = 32'd0;
`endif

    // Combinational CSR read mux; unowned numbers and idle cycles read 0.
    always_comb begin
        timer_rvalue = 32'd0;
        if (csr_re) begin
            case (csr_num)
                CSR_TID:  timer_rvalue = tid;
                CSR_TCFG: timer_rvalue = tcfg;
                CSR_TVAL: timer_rvalue = timer_cnt;
                default:  timer_rvalue = 32'd0;
            endcase
        end
    end

endmodule

// File: tb/tb_csr_timer.sv
// Self-checking bench for csr_timer: directed scenarios plus a randomized
// phase, all compared against a behavioural model of the timer CSRs.
module tb_csr_timer;

  logic        clk;
  logic        reset;
  logic        csr_re;
  logic [13:0] csr_num;
  logic        csr_we;
  logic [31:0] csr_wmask;
  logic [31:0] csr_wvalue;
  logic [31:0] timer_rvalue;
  logic        timer_int;
  logic [31:0] cnt_vl;
  logic [31:0] cnt_vh;
  logic [31:0] tid;

  int total;
  int bad;

  // behavioural model state
  bit [31:0] m_tid;
  bit [31:0] m_tcfg;
  bit [31:0] m_cnt;
  bit        m_int;
  bit [63:0] m_stable;

  logic [31:0] exp_q[$];

  csr_timer #(.CSR_NUM_WIDTH(14)) dut (
    .clk          (clk),
    .reset        (reset),
    .csr_re       (csr_re),
    .csr_num      (csr_num),
    .csr_we       (csr_we),
    .csr_wmask    (csr_wmask),
    .csr_wvalue   (csr_wvalue),
    .timer_rvalue (timer_rvalue),
    .timer_int    (timer_int),
    .cnt_vl       (cnt_vl),
    .cnt_vh       (cnt_vh),
    .tid          (tid)
  );

  // clock / reset block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit [31:0] model_read(input bit [13:0] num);
    case (num)
      14'h40:  return m_tid;
      14'h41:  return m_tcfg;
      14'h42:  return m_cnt;
      default: return 32'd0;
    endcase
  endfunction

  function automatic bit [63:0] exp_stable();
`ifdef CSR_STABLE_COUNTER_EN
    return m_stable;
`else
    return 64'd0;
`endif
  endfunction

  // One clock edge: model computes the post-edge state from the rules, then
  // outputs are compared 1 time unit after the edge.
  task automatic tick();
    bit [31:0] n_tid, n_tcfg, n_cnt, init4;
    bit        n_int;
    if (reset) begin
      n_tid = 0; n_tcfg = 0; n_cnt = 32'hFFFF_FFFF; n_int = 0;
    end else begin
      n_tid  = m_tid;
      n_tcfg = m_tcfg;
      if (csr_we && csr_num == 14'h40) n_tid = (csr_wmask & csr_wvalue) | (~csr_wmask & m_tid);
      if (csr_we && csr_num == 14'h41) n_tcfg = (csr_wmask & csr_wvalue) | (~csr_wmask & m_tcfg);
      init4 = (n_tcfg / 4) * 4;
      n_cnt = m_cnt;
      if (csr_we && csr_num == 14'h41 && n_tcfg % 2 == 1) n_cnt = init4;
      else if (n_tcfg % 2 == 1 && m_cnt != 32'hFFFF_FFFF) begin
        if (m_cnt == 0 && (n_tcfg / 2) % 2 == 1) n_cnt = init4;
        else n_cnt = m_cnt - 1;
      end
      n_int = m_int;
      if (m_tcfg % 2 == 1 && m_cnt == 0) n_int = 1;
      else if (csr_we && csr_num == 14'h44 && (csr_wmask & csr_wvalue) % 2 == 1) n_int = 0;
    end
    @(posedge clk);
    #1;
    m_tid = n_tid; m_tcfg = n_tcfg; m_cnt = n_cnt; m_int = n_int;
    m_stable = reset ? 64'd0 : m_stable + 64'd1;
    csr_we = 1'b0;
    check("timer_int", {63'd0, timer_int}, {63'd0, m_int});
    check("tid", {32'd0, tid}, {32'd0, m_tid});
    check("cnt_vl", {32'd0, cnt_vl}, {32'd0, exp_stable()});
    check("cnt_vh", {32'd0, cnt_vh}, exp_stable() >> 32);
  endtask

  // driver tasks
  task automatic csr_write(input bit [13:0] num, input bit [31:0] mask, input bit [31:0] val);
    csr_we = 1'b1; csr_num = num; csr_wmask = mask; csr_wvalue = val;
    tick();
  endtask

  task automatic csr_read_check(input string tag, input bit [13:0] num);
    csr_re = 1'b1; csr_num = num;
    #1;
    check(tag, {32'd0, timer_rvalue}, {32'd0, model_read(num)});
    csr_re = 1'b0;
  endtask

  initial begin
    int rises;
    bit prev;
    total = 0; bad = 0;
    reset = 1'b1; csr_re = 0; csr_num = 0; csr_we = 0; csr_wmask = 0; csr_wvalue = 0;
    m_tid = 0; m_tcfg = 0; m_cnt = 0; m_int = 0; m_stable = 0;

    // reset and idle
    tick(); tick();
    reset = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    check("idle_int", {63'd0, timer_int}, 64'd0);
    csr_read_check("idle_tval", 14'h42);
    csr_read_check("idle_tcfg", 14'h41);
`ifdef CSR_STABLE_COUNTER_EN
    check("idle_cnt_vl_10", {32'd0, cnt_vl}, 64'd10);
`else
    check("idle_cnt_vl_0", {32'd0, cnt_vl}, 64'd0);
`endif

    // periodic, k=1
    for (int i = 0; i < 11; i++) exp_q.push_back(32'(4 - (i % 5)));
    csr_write(14'h41, 32'hFFFF_FFFF, 32'h0000_0007);
    for (int t = 0; t < 11; t++) begin
      csr_re = 1'b1; csr_num = 14'h42; #1;
      check("periodic_seq", {32'd0, timer_rvalue}, {32'd0, exp_q.pop_front()});
      check("periodic_int", {63'd0, timer_int}, (t >= 5) ? 64'd1 : 64'd0);
      csr_re = 1'b0;
      tick();
    end

    // one-shot, k=2
    csr_write(14'h41, 32'hFFFF_FFFF, 32'h0000_0009);
    csr_write(14'h44, 32'hFFFF_FFFF, 32'h0000_0001);
    check("oneshot_cleared", {63'd0, timer_int}, 64'd0);
    rises = 0;
    for (int t = 0; t < 14; t++) begin
      prev = timer_int;
      tick();
      csr_read_check("oneshot_tval", 14'h42);
      if (!prev && timer_int) rises++;
    end
    check("oneshot_rises", 64'(rises), 64'd1);
    csr_read_check("oneshot_frozen", 14'h42);
    check("oneshot_ffff", {32'd0, timer_rvalue}, 64'hFFFF_FFFF);
    csr_write(14'h44, 32'h0000_0001, 32'hFFFF_FFFF);
    for (int t = 0; t < 4; t++) tick();
    check("oneshot_stays0", {63'd0, timer_int}, 64'd0);

    // periodic InitVal=0: expiry every cycle beats TICLR
    csr_write(14'h41, 32'hFFFF_FFFF, 32'h0000_0003);
    tick(); tick();
    csr_write(14'h44, 32'hFFFF_FFFF, 32'h0000_0001);
    check("set_beats_clear", {63'd0, timer_int}, 64'd1);

    // freeze by clearing En only
    csr_write(14'h41, 32'hFFFF_FFFF, 32'h0000_0017);
    tick(); tick(); tick();
    csr_write(14'h41, 32'h0000_0001, 32'h0000_0000);
    for (int t = 0; t < 4; t++) begin
      csr_read_check("freeze_tval", 14'h42);
      check("freeze_17", {32'd0, timer_rvalue}, 64'd17);
      tick();
    end
    csr_read_check("freeze_tcfg", 14'h41);
    check("freeze_tcfg_16", {32'd0, timer_rvalue}, 64'h16);

    // TID and other reads
    csr_write(14'h40, 32'hFFFF_FFFF, 32'h0000_1234);
    check("tid_port", {32'd0, tid}, 64'h1234);
    csr_read_check("tid_read", 14'h40);
    check("tid_read_1234", {32'd0, timer_rvalue}, 64'h1234);
    csr_read_check("ticlr_read", 14'h44);
    csr_read_check("unowned_read", 14'h00);
    csr_num = 14'h40; csr_re = 1'b0; #1;
    check("no_re_read", {32'd0, timer_rvalue}, 64'd0);

`ifdef CSR_STABLE_COUNTER_EN
    // stable counter wrap of the low word
    force dut.stable_cnt = 64'h0000_0005_FFFF_FFFE;
    #1;
    release dut.stable_cnt;
    m_stable = 64'h0000_0005_FFFF_FFFE;
    tick();
    check("wrap_lo_ffff", {32'd0, cnt_vl}, 64'hFFFF_FFFF);
    tick();
    check("wrap_lo_0", {32'd0, cnt_vl}, 64'd0);
    check("wrap_hi_6", {32'd0, cnt_vh}, 64'd6);
`endif

    // randomized phase
    for (int i = 0; i < 400; i++) begin
      bit [13:0] nums[5];
      nums[0] = 14'h40; nums[1] = 14'h41; nums[2] = 14'h42; nums[3] = 14'h44; nums[4] = 14'h10;
      reset = ($urandom_range(0, 149) == 0);
      if ($urandom_range(0, 3) == 0) begin
        csr_we = 1'b1;
        csr_num = nums[$urandom_range(0, 4)];
        case ($urandom_range(0, 3))
          0: csr_wmask = 32'hFFFF_FFFF;
          1: csr_wmask = 32'h0000_0001;
          2: csr_wmask = 32'h0000_0002;
          default: csr_wmask = $urandom;
        endcase
        csr_wvalue = (csr_num == 14'h41) ? ($urandom & 32'h0000_003F) : $urandom;
      end
      tick();
      reset = 1'b0;
      csr_read_check("rand_read", nums[$urandom_range(0, 4)]);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
